// File: rtl/mouse_ctrl_pkg.sv
// Shared register map, control/status bit positions and fill FSM state type
// for the mouse sprite controller.
package mouse_ctrl_pkg;

  localparam logic [1:0] OFF_PIXEL = 2'd0;
  localparam logic [1:0] OFF_X     = 2'd1;
  localparam logic [1:0] OFF_Y     = 2'd2;
  localparam logic [1:0] OFF_CTRL  = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_FILL_BIT = 1;
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_PEND_BIT = 1;

  localparam int PIX_ADDR_LSB = 16;
  localparam int FILL_VAL_LSB = 8;
  localparam int COORD_W      = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/mouse_fill_engine.sv
// Sprite RAM fill engine: walks addresses 0..FILL_MAX writing one value,
// pausing (counter held) in any cycle the host owns the write port.
module mouse_fill_engine
  import mouse_ctrl_pkg::*;
#(
  parameter int ADDR     = 14,
  parameter int PIX_W    = 1,
  parameter int FILL_MAX = 2**ADDR-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [PIX_W-1:0] value_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic             req_o,
  output logic [ADDR-1:0]  req_addr_o,
  output logic [PIX_W-1:0] req_data_o
);

  fill_state_e      state_q, state_d;
  logic [ADDR-1:0]  cnt_q, cnt_d;
  logic [PIX_W-1:0] val_q, val_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    req_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          val_d   = value_i;
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!stall_i) begin
          req_o = 1'b1;
          cnt_d = cnt_q + ADDR'(1);
          if (cnt_q == ADDR'(FILL_MAX)) state_d = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  assign busy_o     = (state_q == ST_FILL);
  assign req_addr_o = cnt_q;
  assign req_data_o = val_q;

endmodule

// File: rtl/mouse_ctrl.sv
// Mouse sprite controller: shadowed origin/enable committed at frame start,
// registered sprite RAM write port; fill engine present only with MOUSE_CTRL_FILL_EN.
module mouse_ctrl
  import mouse_ctrl_pkg::*;
#(
  parameter int ADDR     = 14,
  parameter int PIX_W    = 1,
  parameter int FILL_MAX = 2**ADDR-1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               write,
  input  logic [1:0]         addr,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  input  logic               frame_start,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic               spr_en,
  output logic               spr_we,
  output logic [ADDR-1:0]    spr_addr,
  output logic [PIX_W-1:0]   spr_din
);

  logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d, x0_q, x0_d, y0_q, y0_d;
  logic               sen_q, sen_d, en_q, en_d, pend_q, pend_d;
  logic               we_q, we_d;
  logic [ADDR-1:0]    waddr_q, waddr_d;
  logic [PIX_W-1:0]   wdin_q, wdin_d;

  logic               bus_we, pix_we;
  logic               fill_busy, fill_req;
  logic [ADDR-1:0]    fill_addr;
  logic [PIX_W-1:0]   fill_data;
  logic               unused_wr;

  assign bus_we    = cs & write;
  assign pix_we    = bus_we && (addr == OFF_PIXEL);
  assign unused_wr = ^wr_data;

`ifdef MOUSE_CTRL_FILL_EN
  logic fill_start;
  assign fill_start = bus_we && (addr == OFF_CTRL) && wr_data[CTRL_FILL_BIT];

  mouse_fill_engine #(
    .ADDR    (ADDR),
    .PIX_W   (PIX_W),
    .FILL_MAX(FILL_MAX)
  ) u_fill (
    .clk       (clk),
    .reset     (reset),
    .start_i   (fill_start),
    .value_i   (wr_data[FILL_VAL_LSB +: PIX_W]),
    .stall_i   (pix_we),
    .busy_o    (fill_busy),
    .req_o     (fill_req),
    .req_addr_o(fill_addr),
    .req_data_o(fill_data)
  );
`else
  localparam int unused_fill_max = FILL_MAX;
  assign fill_busy = 1'b0;
  assign fill_req  = 1'b0;
  assign fill_addr = '0;
  assign fill_data = '0;
`endif

  // Commit reads the pre-write shadow; a same-cycle shadow write re-arms pending.
  always_comb begin
    sx_d   = sx_q;
    sy_d   = sy_q;
    sen_d  = sen_q;
    x0_d   = x0_q;
    y0_d   = y0_q;
    en_d   = en_q;
    pend_d = pend_q;
    if (frame_start && pend_q) begin
      x0_d   = sx_q;
      y0_d   = sy_q;
      en_d   = sen_q;
      pend_d = 1'b0;
    end
    if (bus_we) begin
      case (addr)
        OFF_X:    begin sx_d  = wr_data[COORD_W-1:0]; pend_d = 1'b1; end
        OFF_Y:    begin sy_d  = wr_data[COORD_W-1:0]; pend_d = 1'b1; end
        OFF_CTRL: begin sen_d = wr_data[CTRL_EN_BIT]; pend_d = 1'b1; end
        default:  ;
      endcase
    end
  end

  always_comb begin
    we_d    = pix_we | fill_req;
    waddr_d = waddr_q;
    wdin_d  = wdin_q;
    if (pix_we) begin
      waddr_d = wr_data[PIX_ADDR_LSB +: ADDR];
      wdin_d  = wr_data[PIX_W-1:0];
    end else if (fill_req) begin
      waddr_d = fill_addr;
      wdin_d  = fill_data;
    end
  end

  // NOTE: reset is synchronous here, so it is simply the highest-priority branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (reset) begin
      sx_q    <= '0;
      sy_q    <= '0;
      sen_q   <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdin_q  <= '0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sen_q   <= sen_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdin_q  <= wdin_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      OFF_PIXEL: begin
        rd_data[STAT_BUSY_BIT] = fill_busy;
        rd_data[STAT_PEND_BIT] = pend_q;
      end
      OFF_X:    rd_data[COORD_W-1:0] = x0_q;
      OFF_Y:    rd_data[COORD_W-1:0] = y0_q;
      OFF_CTRL: rd_data[0]           = en_q;
      default:  ;
    endcase
  end

  assign x0       = x0_q;
  assign y0       = y0_q;
  assign spr_en   = en_q;
  assign spr_we   = we_q;
  assign spr_addr = waddr_q;
  assign spr_din  = wdin_q;

endmodule

// File: tb/tb_mouse_ctrl.sv
// Self-checking bench for mouse_ctrl: directed table, multi-cycle corner cases and
// randomized traffic against a cycle-level reference model (fill parts need MOUSE_CTRL_FILL_EN).
module tb_mouse_ctrl;

  localparam int ADDR     = 14;
  localparam int PIX_W    = 1;
  localparam int FILL_MAX = 2**ADDR-1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cs = 1'b0, write = 1'b0, frame_start = 1'b0;
  logic [1:0]        addr = 2'd0;
  logic [31:0]       wr_data = '0;
  logic [31:0]       rd_data;
  logic [10:0]       x0, y0;
  logic              spr_en, spr_we;
  logic [ADDR-1:0]   spr_addr;
  logic [PIX_W-1:0]  spr_din;

  mouse_ctrl #(.ADDR(ADDR), .PIX_W(PIX_W), .FILL_MAX(FILL_MAX)) dut (
    .clk(clk), .reset(reset), .cs(cs), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .frame_start(frame_start),
    .x0(x0), .y0(y0), .spr_en(spr_en), .spr_we(spr_we),
    .spr_addr(spr_addr), .spr_din(spr_din)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_we  = 0;

  // Reference model state
  logic [10:0]      m_sx, m_sy, m_x0, m_y0;
  logic             m_sen, m_en, m_pend;
  bit               m_fill;
  int               m_fcnt;
  logic [PIX_W-1:0] m_fval;
  logic             m_we;
  logic [ADDR-1:0]  m_wa;
  logic [PIX_W-1:0] m_wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sx = '0; m_sy = '0; m_x0 = '0; m_y0 = '0;
    m_sen = 1'b0; m_en = 1'b0; m_pend = 1'b0;
    m_fill = 1'b0; m_fcnt = 0; m_fval = '0;
    m_we = 1'b0; m_wa = '0; m_wd = '0;
  endtask

  task automatic model_step(input logic c, input logic w, input logic [1:0] a,
                            input logic [31:0] d, input logic f);
    bit bw, pix, was_fill;
    bw       = c && w;
    pix      = bw && (a == 2'd0);
    was_fill = m_fill;
    m_we     = 1'b0;
    if (pix) begin
      m_we = 1'b1; m_wa = d[16 +: ADDR]; m_wd = d[PIX_W-1:0];
    end
`ifdef MOUSE_CTRL_FILL_EN
    if (was_fill && !pix) begin
      m_we = 1'b1; m_wa = ADDR'(m_fcnt); m_wd = m_fval;
      if (m_fcnt == FILL_MAX) m_fill = 1'b0;
      m_fcnt++;
    end
    if (bw && a == 2'd3 && d[1] && !was_fill) begin
      m_fill = 1'b1; m_fcnt = 0; m_fval = d[8 +: PIX_W];
    end
`endif
    if (f && m_pend) begin
      m_x0 = m_sx; m_y0 = m_sy; m_en = m_sen; m_pend = 1'b0;
    end
    if (bw) begin
      if (a == 2'd1) begin m_sx = d[10:0]; m_pend = 1'b1; end
      if (a == 2'd2) begin m_sy = d[10:0]; m_pend = 1'b1; end
      if (a == 2'd3) begin m_sen = d[0];   m_pend = 1'b1; end
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {30'b0, m_pend, m_fill};
      2'd1:    return {21'b0, m_x0};
      2'd2:    return {21'b0, m_y0};
      default: return {31'b0, m_en};
    endcase
  endfunction

  function automatic logic [63:0] act_pack();
    return 64'({x0, y0, spr_en, spr_we, spr_we ? spr_addr : ADDR'(0), spr_we ? spr_din : PIX_W'(0)});
  endfunction

  function automatic logic [63:0] exp_pack();
    return 64'({m_x0, m_y0, m_en, m_we, m_we ? m_wa : ADDR'(0), m_we ? m_wd : PIX_W'(0)});
  endfunction

  // One bus cycle: drive, check combinational read, clock, check registered outputs.
  task automatic cycle(input logic c, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic f);
    cs = c; write = w; addr = a; wr_data = d; frame_start = f;
    #1;
    check("rd_data", 64'(rd_data), 64'(exp_rd(a)));
    @(posedge clk); #1;
    model_step(c, w, a, d, f);
    check("outputs", act_pack(), exp_pack());
    if (spr_we) n_we++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'(i % 4), 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; cs = 1'b0; write = 1'b0; frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_outputs", act_pack(), 64'h0);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check("reset_rd_data", 64'(rd_data), 64'h0);
    end
    reset = 1'b0;
  endtask

  typedef struct {
    logic        c, w;
    logic [1:0]  a;
    logic [31:0] d;
    logic        f;
    logic [10:0] ex, ey;
    logic        een, epend;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 1, 2'd1, 32'd100,        0, 11'd0,   11'd0,    0, 1};
    tbl[1]  = '{1, 1, 2'd2, 32'd50,         0, 11'd0,   11'd0,    0, 1};
    tbl[2]  = '{1, 1, 2'd3, 32'd1,          0, 11'd0,   11'd0,    0, 1};
    tbl[3]  = '{0, 0, 2'd0, 32'd0,          1, 11'd100, 11'd50,   1, 0};
    tbl[4]  = '{0, 0, 2'd0, 32'd0,          1, 11'd100, 11'd50,   1, 0};
    tbl[5]  = '{1, 1, 2'd1, 32'd3,          0, 11'd100, 11'd50,   1, 1};
    tbl[6]  = '{1, 1, 2'd1, 32'd7,          1, 11'd3,   11'd50,   1, 1};
    tbl[7]  = '{0, 0, 2'd0, 32'd0,          1, 11'd7,   11'd50,   1, 0};
    tbl[8]  = '{1, 1, 2'd3, 32'd0,          0, 11'd7,   11'd50,   1, 1};
    tbl[9]  = '{1, 1, 2'd2, 32'd2047,       0, 11'd7,   11'd50,   1, 1};
    tbl[10] = '{0, 0, 2'd0, 32'd0,          1, 11'd7,   11'd2047, 0, 0};
    tbl[11] = '{1, 1, 2'd1, 32'hFFFF_F805,  0, 11'd7,   11'd2047, 0, 1};
    tbl[12] = '{0, 0, 2'd0, 32'd0,          1, 11'd5,   11'd2047, 0, 0};

    model_reset();
    do_reset();

    // Shadow/commit table
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f);
      check("tbl_x0", 64'(x0), 64'(tbl[i].ex));
      check("tbl_y0", 64'(y0), 64'(tbl[i].ey));
      check("tbl_en", 64'(spr_en), 64'(tbl[i].een));
      cs = 1'b0; write = 1'b0; addr = 2'd0; frame_start = 1'b0;
      #1;
      check("tbl_pending", 64'(rd_data[1]), 64'(tbl[i].epend));
    end

    // Shadow write held without frame_start
    cycle(1'b1, 1'b1, 2'd1, 32'd9, 1'b0);
    idle(1000);
    check("x0_hold", 64'(x0), 64'd5);
    cs = 1'b0; write = 1'b0; addr = 2'd0;
    #1;
    check("pending_hold", 64'(rd_data), 64'h2);
    cycle(1'b0, 1'b0, 2'd1, 32'd0, 1'b1);
    check("x0_commit9", 64'(x0), 64'd9);

    // Host pixel writes
    cycle(1'b1, 1'b1, 2'd0, 32'h1234_0001, 1'b0);
    check("pix_addr", 64'({spr_we, spr_addr, spr_din}), 64'({1'b1, 14'h1234, 1'b1}));
    cycle(1'b0, 1'b1, 2'd0, 32'h0055_0001, 1'b0);
    check("pix_no_cs", 64'(spr_we), 64'd0);
    cycle(1'b1, 1'b0, 2'd0, 32'h3FFF_0001, 1'b0);
    check("pix_no_wr", 64'(spr_we), 64'd0);
    cycle(1'b1, 1'b1, 2'd0, 32'h3FFF_0000, 1'b0);
    check("pix_top_addr", 64'({spr_we, spr_addr, spr_din}), 64'({1'b1, 14'h3FFF, 1'b0}));

`ifdef MOUSE_CTRL_FILL_EN
    // Uncontended fill, value 1
    n_we = 0;
    cycle(1'b1, 1'b1, 2'd3, 32'h0000_0102, 1'b0);
    idle(FILL_MAX + 1);
    check("fill_writes", 64'(n_we), 64'(FILL_MAX + 1));
    addr = 2'd0;
    #1;
    check("fill_done_busy", 64'(rd_data[0]), 64'd0);
    idle(2);

    // Fill contended by a host write
    n_we = 0;
    cycle(1'b1, 1'b1, 2'd3, 32'h0000_0002, 1'b0);
    cycle(1'b1, 1'b1, 2'd3, 32'h0000_0102, 1'b0);
    idle(100);
    cycle(1'b1, 1'b1, 2'd0, 32'h1234_0000, 1'b0);
    check("host_prio", 64'({spr_we, spr_addr, spr_din}), 64'({1'b1, 14'h1234, 1'b0}));
    for (int g = 0; g < 20000 && m_fill; g++) idle(1);
    check("fill_total", 64'(n_we), 64'(FILL_MAX + 2));

    // Reset mid-fill
    cycle(1'b1, 1'b1, 2'd3, 32'h0000_0102, 1'b0);
    for (int g = 0; g < 1000 && m_fcnt < 500; g++) idle(1);
    do_reset();
    n_we = 0;
    idle(200);
    check("post_reset_writes", 64'(n_we), 64'd0);
`else
    // Fill start has no effect without the fill engine
    n_we = 0;
    cycle(1'b1, 1'b1, 2'd3, 32'h0000_0103, 1'b0);
    idle(50);
    check("nofill_writes", 64'(n_we), 64'd0);
    addr = 2'd0;
    #1;
    check("nofill_busy", 64'(rd_data[0]), 64'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic c, w, f;
      logic [1:0] a;
      logic [31:0] d;
      c = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd3 && $urandom_range(0, 15) != 0) d[1] = 1'b0;
      f = ($urandom_range(0, 15) == 0);
      cycle(c, w, a, d, f);
    end
    for (int g = 0; g < 20000 && m_fill; g++) idle(1);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mouse_ctrl.md
MOUSE_CTRL -- requirements
Module: mouse_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default 14: sprite RAM address width (128x128 sprite).
REQ-002 SHALL have parameter PIX_W, default 1: sprite RAM pixel (palette code) width.
REQ-003 SHALL have parameter FILL_MAX, default 2**ADDR-1: last address written by the fill engine.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port cs  in  1  bus chip select.
REQ-007 SHALL have port write  in  1  bus write strobe, qualified by cs.
REQ-008 SHALL have port addr  in  2  register offset.
REQ-009 SHALL have port wr_data  in  32  bus write data.
REQ-010 SHALL have port rd_data  out  32  bus read data.
REQ-011 SHALL have port frame_start  in  1  one-cycle pulse at start of each video frame.
REQ-012 SHALL have port x0  out  11  committed sprite origin x.
REQ-013 SHALL have port y0  out  11  committed sprite origin y.
REQ-014 SHALL have port spr_en  out  1  committed sprite enable.
REQ-015 SHALL have port spr_we  out  1  sprite RAM write enable.
REQ-016 SHALL have port spr_addr  out  ADDR  sprite RAM write address.
REQ-017 SHALL have port spr_din  out  PIX_W  sprite RAM write data.

Function
REQ-018 SHALL decode bus write (cs&write): offset 0 = pixel write (address wr_data[16+ADDR-1:16], data wr_data[PIX_W-1:0]); 1 = shadow x (wr_data[10:0]); 2 = shadow y; 3 = control (bit0 shadow enable, bit1 fill start, fill value wr_data[8+PIX_W-1:8]).
REQ-019 SHALL drive rd_data combinationally from addr: 0 = {30'b0, pending, busy}; 1 = x0; 2 = y0; 3 = spr_en; unused bits zero.
REQ-020 SHALL set pending on any write to offsets 1, 2 or control bit0 path (offset 3).
REQ-021 SHALL, on frame_start with pending=1, copy shadow x/y/enable to x0/y0/spr_en, visible the next cycle, and clear pending.
REQ-022 SHALL, on frame_start with pending=0, leave x0/y0/spr_en unchanged.
REQ-023 SHALL, on simultaneous frame_start and shadow write, commit the pre-write shadow values and leave pending=1.
REQ-024 SHALL register spr_we/spr_addr/spr_din: a write appears on them exactly one cycle after the accepted bus cycle or FSM decision; spr_we=0 otherwise.
REQ-025 SHALL implement fill FSM states IDLE and FILL; busy=1 iff state is FILL.
REQ-026 SHALL, in IDLE on fill start, latch fill value, clear counter to 0, enter FILL.
REQ-027 SHALL, in FILL, each cycle with no host pixel write, issue write (counter, fill value), increment counter; after writing FILL_MAX return to IDLE.
REQ-028 SHALL give host pixel writes priority: in that cycle the host write is issued and the fill counter holds.
REQ-029 SHALL ignore fill start while in FILL (no restart, value unchanged).
REQ-030 SHALL complete an uncontended fill in FILL_MAX+1 cycles; busy drops the cycle after the final write is decided.

Reset
REQ-031 SHALL on reset set x0=y0=0, spr_en=0, shadow registers 0, pending=0, state IDLE, counter 0, spr_we=0, spr_addr=0, spr_din=0.
REQ-032 SHALL on reset mid-fill abort immediately; no further fill writes are issued.

Configuration
REQ-033 SHALL, when MOUSE_CTRL_FILL_EN is defined, include the fill FSM as specified.
REQ-034 SHALL, when MOUSE_CTRL_FILL_EN is undefined, omit the FSM: control bit1 ignored, busy reads 0, only host pixel writes reach spr_*.

Structure
REQ-035 SHALL place register offsets, control/status bit positions and the fill state enum typedef in package mouse_ctrl_pkg.
REQ-036 SHALL implement the fill FSM and counter as sub-module mouse_fill_engine (stall input, write request outputs).

Verification
REQ-037 SHALL cover: write x=100, y=50, ctrl=1, then frame_start -> next cycle x0=100, y0=50, spr_en=1, pending=0.
REQ-038 SHALL cover: shadow x write with no frame_start for 1000 cycles -> x0 unchanged, status reads pending=1.
REQ-039 SHALL cover: write x=7 in the same cycle as frame_start after prior x=3 pending -> x0=3, pending=1; next frame_start -> x0=7.
REQ-040 SHALL cover: fill start value 1, no contention -> 16384 writes addr 0..16383 data 1 on consecutive cycles, busy then 0.
REQ-041 SHALL cover: host pixel write addr 0x1234 data 0 during fill -> that cycle spr_addr=0x1234, fill resumes next cycle at held counter, total fill still complete.
REQ-042 SHALL cover: reset asserted at counter 500 -> spr_we=0 after reset, busy=0, no further writes.
